// File: rtl/nemesis_bus_pkg.sv
// Shared types for the Nemesis 68000 bus controller: FSM states, decoded
// regions, counter widths and the chip-select priority encoder.
package nemesis_bus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ROM,
        ST_OBJ,
        ST_ACK,
        ST_HOLD
    } bus_state_t;

    typedef enum logic [2:0] {
        REG_PROM,
        REG_OBJ,
        REG_RAM,
        REG_VID,
        REG_IO,
        REG_EXT,
        REG_NONE
    } region_t;

    localparam int WS_W    = 4;
    localparam int STALL_W = 4;

    // Fixed decode priority; selects are mutually exclusive on real hardware,
    // the priority only matters for a glitched or misprogrammed decoder.
    function automatic region_t decode_region(
        input logic prom_cs_n,
        input logic objram_n,
        input logic ram_cs_n,
        input logic chara_n,
        input logic vid_cs_n,
        input logic io_cs_n,
        input logic excs_n
    );
        if (!prom_cs_n)                 return REG_PROM;
        else if (!objram_n)             return REG_OBJ;
        else if (!ram_cs_n || !chara_n) return REG_RAM;
        else if (!vid_cs_n)             return REG_VID;
        else if (!io_cs_n)              return REG_IO;
        else if (!excs_n)               return REG_EXT;
        else                            return REG_NONE;
    endfunction

endpackage

// File: rtl/nemesis_objram_arb.sv
// Object-RAM port arbiter between the CPU and the sprite scan engine.
// Sprite has priority until the CPU has been starved MAX_STALL times.
module nemesis_objram_arb
    import nemesis_bus_pkg::*;
#(
    parameter int CPU_SLOT  = 2,
    parameter int MAX_STALL = 7
) (
    input  logic clk,
    input  logic srst,
    input  logic cpu_req,
    input  logic spr_req,
    output logic spr_gnt,
    output logic obj_cpu,
    output logic cpu_done
);

    localparam int SLOT_W = $clog2(CPU_SLOT + 1);

    logic [SLOT_W-1:0]  slot_cnt_reg, slot_cnt_next;
    logic [STALL_W-1:0] stall_reg, stall_next;
    logic               spr_gnt_reg, spr_gnt_next;
    logic               cpu_wins;

    always_comb begin
        slot_cnt_next = slot_cnt_reg;
        stall_next    = stall_reg;
        spr_gnt_next  = 1'b0;
        cpu_wins      = cpu_req && (!spr_req || (stall_reg >= STALL_W'(MAX_STALL)));

        if (slot_cnt_reg != '0) begin
            slot_cnt_next = slot_cnt_reg - SLOT_W'(1);
            // A sprite kept waiting by the slot gets the port as soon as it ends
            spr_gnt_next  = (slot_cnt_reg == SLOT_W'(1)) && spr_req;
        end else if (cpu_wins) begin
            slot_cnt_next = SLOT_W'(CPU_SLOT);
            stall_next    = '0;
        end else if (spr_req && !spr_gnt_reg) begin
            // The cycle after a grant the engine has not yet dropped its request
            spr_gnt_next = 1'b1;
            if (cpu_req && (stall_reg != '1))
                stall_next = stall_reg + STALL_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            slot_cnt_reg <= '0;
            stall_reg    <= '0;
            spr_gnt_reg  <= 1'b0;
        end else begin
            slot_cnt_reg <= slot_cnt_next;
            stall_reg    <= stall_next;
            spr_gnt_reg  <= spr_gnt_next;
        end
    end

    assign spr_gnt  = spr_gnt_reg;
    assign obj_cpu  = (slot_cnt_reg != '0);
    assign cpu_done = (slot_cnt_reg == SLOT_W'(1));

endmodule

// File: rtl/nemesis_68k_bus_ctrl.sv
// 68000 bus-cycle sequencer: DTACK wait states, PROM fetch via SDRAM, object-RAM
// arbitration. Define NEMESIS_BERR_EN to add the bus-error watchdog.
module nemesis_68k_bus_ctrl
    import nemesis_bus_pkg::*;
#(
    parameter int RAM_WS    = 0,
    parameter int VID_WS    = 1,
    parameter int IO_WS     = 0,
    parameter int CPU_SLOT  = 2,
    parameter int MAX_STALL = 7
`ifdef NEMESIS_BERR_EN
    ,
    parameter int BERR_CYC  = 255
`endif
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_cen,
    input  logic i_as_n,
    input  logic i_rw,
    input  logic i_prom_cs_n,
    input  logic i_ram_cs_n,
    input  logic i_chara,
    input  logic i_vid_cs_n,
    input  logic i_objram,
    input  logic i_io_cs_n,
    input  logic i_excs_n,
    output logic o_sdram_req,
    input  logic i_sdram_ack,
    input  logic i_spr_req,
    output logic o_spr_gnt,
    output logic o_obj_cpu,
    output logic o_dtack_n,
    output logic o_berr_n
);

    bus_state_t      state_reg, state_next;
    region_t         region_reg, region_next;
    region_t         sel_region;
    logic [WS_W-1:0] ws_cnt_reg, ws_cnt_next;
    logic [WS_W-1:0] sel_ws;
    logic            dtack_n_reg, dtack_n_next;
    logic            as_q_reg, as_qq_reg;
    logic            as_fall;
    logic            obj_done;
    logic            berr_fire;
    logic            berr_active;

    // AS history resets low so a cycle interrupted by reset is never resumed
    assign as_fall    = as_qq_reg && !as_q_reg;
    assign sel_region = decode_region(i_prom_cs_n, i_objram, i_ram_cs_n, i_chara,
                                      i_vid_cs_n, i_io_cs_n, i_excs_n);

    // Expansion space has no dedicated wait parameter; it behaves like I/O
    always_comb begin
        sel_ws = '0;
        case (sel_region)
            REG_RAM:         sel_ws = WS_W'(RAM_WS);
            REG_VID:         sel_ws = WS_W'(VID_WS);
            REG_IO, REG_EXT: sel_ws = WS_W'(IO_WS);
            default:         sel_ws = '0;
        endcase
    end

    always_comb begin
        state_next   = state_reg;
        region_next  = region_reg;
        ws_cnt_next  = ws_cnt_reg;
        dtack_n_next = 1'b1;
        case (state_reg)
            ST_IDLE: begin
                if (as_fall) begin
                    region_next = sel_region;
                    case (sel_region)
                        REG_PROM: state_next = i_rw ? ST_ROM : ST_ACK;
                        REG_OBJ:  state_next = ST_OBJ;
                        REG_NONE: state_next = ST_HOLD;
                        default: begin
                            if (sel_ws == '0) begin
                                state_next = ST_ACK;
                            end else begin
                                state_next  = ST_WAIT;
                                ws_cnt_next = sel_ws;
                            end
                        end
                    endcase
                end
            end
            ST_WAIT: begin
                if (i_cen) begin
                    if (ws_cnt_reg <= WS_W'(1)) begin
                        state_next  = ST_ACK;
                        ws_cnt_next = '0;
                    end else begin
                        ws_cnt_next = ws_cnt_reg - WS_W'(1);
                    end
                end
            end
            ST_ROM:  if (i_sdram_ack) state_next = ST_ACK;
            ST_OBJ:  if (obj_done) state_next = ST_ACK;
            ST_ACK: begin
                state_next   = i_as_n ? ST_IDLE : ST_HOLD;
                dtack_n_next = i_as_n;
            end
            ST_HOLD: begin
                if (i_as_n)
                    state_next = ST_IDLE;
                else
                    dtack_n_next = (region_reg == REG_NONE) || berr_active;
            end
            default: state_next = ST_IDLE;
        endcase
        if (berr_fire) begin
            state_next   = ST_HOLD;
            dtack_n_next = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg   <= ST_IDLE;
            region_reg  <= REG_NONE;
            ws_cnt_reg  <= '0;
            dtack_n_reg <= 1'b1;
            as_q_reg    <= 1'b0;
            as_qq_reg   <= 1'b0;
        end else begin
            state_reg   <= state_next;
            region_reg  <= region_next;
            ws_cnt_reg  <= ws_cnt_next;
            dtack_n_reg <= dtack_n_next;
            as_q_reg    <= i_as_n;
            as_qq_reg   <= as_q_reg;
        end
    end

`ifdef NEMESIS_BERR_EN
    logic [7:0] wd_cnt_reg;
    logic       berr_n_reg;
    logic       wd_tick;

    // Open-bus HOLD counts too, so an unmapped access eventually faults
    assign wd_tick   = i_cen && berr_n_reg &&
                       ((state_reg inside {ST_WAIT, ST_ROM, ST_OBJ, ST_ACK}) ||
                        ((state_reg == ST_HOLD) && (region_reg == REG_NONE)));
    assign berr_fire = wd_tick && (wd_cnt_reg == 8'(BERR_CYC - 1));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wd_cnt_reg <= '0;
            berr_n_reg <= 1'b1;
        end else begin
            if (state_reg == ST_IDLE)
                wd_cnt_reg <= '0;
            else if (wd_tick)
                wd_cnt_reg <= wd_cnt_reg + 8'd1;
            if (berr_fire)
                berr_n_reg <= 1'b0;
            else if ((state_reg == ST_HOLD) && i_as_n)
                berr_n_reg <= 1'b1;
        end
    end

    assign berr_active = !berr_n_reg;
    assign o_berr_n    = berr_n_reg;
`else
    assign berr_fire   = 1'b0;
    assign berr_active = 1'b0;
    assign o_berr_n    = 1'b1;
`endif

    nemesis_objram_arb #(
        .CPU_SLOT  (CPU_SLOT),
        .MAX_STALL (MAX_STALL)
    ) u_arb (
        .clk      (i_clk),
        .srst     (i_rst),
        .cpu_req  (state_reg == ST_OBJ),
        .spr_req  (i_spr_req),
        .spr_gnt  (o_spr_gnt),
        .obj_cpu  (o_obj_cpu),
        .cpu_done (obj_done)
    );

    assign o_sdram_req = (state_reg == ST_ROM);
    assign o_dtack_n   = dtack_n_reg;

endmodule
